// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master memory arbiter: FSM states, granted operation
// kind and the number of masters served.
package mem_arb_pkg;

   localparam int MASTER_NUM = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_RD = 2'd1,
      BUSY_WR = 2'd2
   } arb_state_e;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } arb_op_e;

endpackage

// File: rtl/mem_arbiter2_rr_pick2.sv
// Combinational two-way round-robin picker: a lone requester always wins,
// and a tie goes to the master selected by ptr_i.
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic [MASTER_NUM-1:0] req_i,
   input  logic                  ptr_i,
   output logic [MASTER_NUM-1:0] gnt_o
);

   always_comb begin
      gnt_o = '0;
      case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = ptr_i ? 2'b10 : 2'b01;
         default: gnt_o = '0;
      endcase
   end

endmodule

// File: rtl/mem_arbiter2.sv
// Two-master round-robin arbiter in front of one line-wide memory slave.
// A whole read or write is granted at a time; responses return only to the owner.
module mem_arbiter2
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 128
) (
   input  logic                    clk,
   input  logic                    rstn,
   // master 0
   input  logic                    m0_ren_i,
   input  logic [ADDR_WIDTH-1:0]   m0_raddr_i,
   input  logic                    m0_wen_i,
   input  logic [ADDR_WIDTH-1:0]   m0_waddr_i,
   input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] m0_wmask_i,
   output logic [DATA_WIDTH-1:0]   m0_rdata_o,
   output logic                    m0_rvalid_o,
   output logic                    m0_wvalid_o,
   // master 1
   input  logic                    m1_ren_i,
   input  logic [ADDR_WIDTH-1:0]   m1_raddr_i,
   input  logic                    m1_wen_i,
   input  logic [ADDR_WIDTH-1:0]   m1_waddr_i,
   input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] m1_wmask_i,
   output logic [DATA_WIDTH-1:0]   m1_rdata_o,
   output logic                    m1_rvalid_o,
   output logic                    m1_wvalid_o,
   // memory slave
   output logic                    mem_ren_o,
   output logic [ADDR_WIDTH-1:0]   mem_raddr_o,
   output logic                    mem_wen_o,
   output logic [ADDR_WIDTH-1:0]   mem_waddr_o,
   output logic [DATA_WIDTH-1:0]   mem_wdata_o,
   output logic [DATA_WIDTH/8-1:0] mem_wmask_o,
   input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
   input  logic                    mem_rvalid_i,
   input  logic                    mem_wvalid_i
);

   localparam int MASK_WIDTH = DATA_WIDTH / 8;

   arb_state_e state_q, state_d;
   arb_op_e    op_q, op_d;
   logic       owner_q, owner_d;
   logic       rr_ptr_q, rr_ptr_d;

   logic [MASTER_NUM-1:0] ren_vec, wen_vec, req_vec, gnt_vec;
   logic [MASTER_NUM-1:0] rvalid_vec, wvalid_vec;
   logic [ADDR_WIDTH-1:0] raddr_arr [MASTER_NUM];
   logic [ADDR_WIDTH-1:0] waddr_arr [MASTER_NUM];
   logic [DATA_WIDTH-1:0] wdata_arr [MASTER_NUM];
   logic [MASK_WIDTH-1:0] wmask_arr [MASTER_NUM];

   logic rd_active, wr_active, gnt_idx;

   assign ren_vec      = {m1_ren_i, m0_ren_i};
   assign wen_vec      = {m1_wen_i, m0_wen_i};
   assign raddr_arr[0] = m0_raddr_i;
   assign raddr_arr[1] = m1_raddr_i;
   assign waddr_arr[0] = m0_waddr_i;
   assign waddr_arr[1] = m1_waddr_i;
   assign wdata_arr[0] = m0_wdata_i;
   assign wdata_arr[1] = m1_wdata_i;
   assign wmask_arr[0] = m0_wmask_i;
   assign wmask_arr[1] = m1_wmask_i;

   rr_pick2 u_pick (
      .req_i (req_vec),
      .ptr_i (rr_ptr_q),
      .gnt_o (gnt_vec)
   );

   // Grant is one-hot, so its upper bit is the index of the winning master.
   assign gnt_idx = gnt_vec[1];

   // rstn is folded in so the memory request drops in the very cycle reset is applied.
   assign rd_active = rstn && (state_q == BUSY_RD) && (op_q == OP_RD);
   assign wr_active = rstn && (state_q == BUSY_WR) && (op_q == OP_WR);

   genvar gi;
   generate
      for (gi = 0; gi < MASTER_NUM; gi++) begin : g_master
         assign req_vec[gi]    = ren_vec[gi] | wen_vec[gi];
         assign rvalid_vec[gi] = rd_active && (owner_q == 1'(gi)) && mem_rvalid_i;
         assign wvalid_vec[gi] = wr_active && (owner_q == 1'(gi)) && mem_wvalid_i;
      end
   endgenerate

   assign mem_ren_o   = rd_active;
   assign mem_raddr_o = rd_active ? raddr_arr[owner_q] : '0;
   assign mem_wen_o   = wr_active;
   assign mem_waddr_o = wr_active ? waddr_arr[owner_q] : '0;
   assign mem_wdata_o = wr_active ? wdata_arr[owner_q] : '0;
   assign mem_wmask_o = wr_active ? wmask_arr[owner_q] : '0;

   assign m0_rdata_o  = mem_rdata_i;
   assign m1_rdata_o  = mem_rdata_i;
   assign m0_rvalid_o = rvalid_vec[0];
   assign m1_rvalid_o = rvalid_vec[1];
   assign m0_wvalid_o = wvalid_vec[0];
   assign m1_wvalid_o = wvalid_vec[1];

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         IDLE: begin
            if (|gnt_vec) begin
               owner_d = gnt_idx;
               // A write outranks a read that the same master presents alongside it.
               if (wen_vec[gnt_idx]) begin
                  state_d = BUSY_WR;
                  op_d    = OP_WR;
               end else begin
                  state_d = BUSY_RD;
                  op_d    = OP_RD;
               end
            end
         end
         BUSY_RD: begin
            if (mem_rvalid_i) begin
               state_d  = IDLE;
               rr_ptr_d = ~owner_q;
            end
         end
         BUSY_WR: begin
            if (mem_wvalid_i) begin
               state_d  = IDLE;
               rr_ptr_d = ~owner_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q  <= IDLE;
         op_q     <= OP_RD;
         owner_q  <= 1'b0;
         rr_ptr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

endmodule
